// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Purpose  : Shared UART types and line constants for the transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } tx_state_t;

  localparam int   UART_DATA_BITS   = 8;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_tick
// Purpose  : Bit-period counter; tick pulses on the last cycle of each period.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
  parameter int clock_divide = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int                CNT_W   = $clog2(clock_divide);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(clock_divide - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Holding clear keeps the count at zero so a period starts with the start bit.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q + CNT_W'(1);
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      tick  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : UART transmitter (start, 8 data bits LSB first, stop) with a
//            one-entry holding register. Define UART_TX_PARITY_EN to add a
//            parity bit (even, or odd when parity_odd=1) before the stop bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int clk_freq   = 50000000,
  parameter int baud_rate  = 19200,
  parameter bit parity_odd = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data_in,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int CLOCK_DIVIDE = clk_freq / baud_rate;
  localparam int IDX_W        = $clog2(UART_DATA_BITS);

  tx_state_t                 state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] hold_data_q, hold_data_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      hold_full_q, hold_full_d;
  logic                      tx_q, tx_d;
  logic                      accept, tick, clear;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`else
  logic                      unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  assign clear = (state_q == IDLE);

  uart_baud_tick #(
    .clock_divide(CLOCK_DIVIDE)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .tick (tick)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    accept      = tx_valid && !hold_full_q;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    if (accept) begin
      hold_data_d = tx_data_in;
    end
    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          shift_d     = hold_data_q;
          hold_full_d = 1'b0;
          state_d     = START;
`ifdef UART_TX_PARITY_EN
          parity_d    = parity_odd ? ~^hold_data_q : ^hold_data_q;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == IDX_W'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A byte accepted on the load edge refills the register.
    if (accept) begin
      hold_full_d = 1'b1;
    end

    // Line level is registered from the next state so it changes with the state.
    case (state_d)
      START:   tx_d = UART_START_LEVEL;
      DATA:    tx_d = shift_d[idx_d];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = UART_STOP_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_data_q <= '0;
      idx_q       <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= UART_STOP_LEVEL;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_data_q <= hold_data_d;
      idx_q       <= idx_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign tx       = tx_q;
  assign tx_ready = !hold_full_q;
  assign tx_busy  = (state_q != IDLE);
  assign tx_done  = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Scoreboard bench for uart_tx (short-period and default-rate DUTs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;
  localparam int CD   = 8;
  localparam int CD2  = 50000000 / 19200;
  localparam bit PODD = 1'b0;
`ifdef UART_TX_PARITY_EN
  localparam int NB     = 11;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int NB     = 10;
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0, tx_valid2 = 1'b0;
  logic [7:0] tx_data_in = 8'h00, tx_data2 = 8'h00;
  logic       tx_ready, tx, tx_busy, tx_done;
  logic       tx_ready2, tx2, tx_busy2, tx_done2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_fall = 0;
  int last_gap  = 0;
  bit mon_busy  = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.clk_freq(8), .baud_rate(1), .parity_odd(PODD)) u_dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data_in(tx_data_in),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_tx u_dut_def (
    .clk(clk), .rst(rst), .tx_valid(tx_valid2), .tx_data_in(tx_data2),
    .tx_ready(tx_ready2), .tx(tx2), .tx_busy(tx_busy2), .tx_done(tx_done2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_par(input logic [7:0] d);
    return PODD ? ~^d : ^d;
  endfunction

  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic [10:0] f;
    f = '0;
    f[8:1] = d;
    if (PAR_EN) begin
      f[9]  = exp_par(d);
      f[10] = 1'b1;
    end else begin
      f[9]  = 1'b1;
    end
    return f;
  endfunction

  // Frame monitor for the short-period DUT: rebuild each frame and score it.
  initial begin : mon_a
    logic [10:0] frame;
    logic [7:0]  e;
    bit aborted, stable, early;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        mon_busy  = 1'b1;
        last_gap  = cyc - last_fall;
        last_fall = cyc;
        frame = '0; aborted = 1'b0; stable = 1'b1; early = 1'b0;
        for (int b = 0; b < NB; b++) begin
          for (int k = 0; k < CD; k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (rst !== 1'b1) aborted = 1'b1;
            if (!aborted) begin
              if (k == 0) frame[b] = tx;
              else if (tx !== frame[b]) stable = 1'b0;
              if (tx_done === 1'b1) early = 1'b1;
            end
          end
        end
        if (!aborted) begin
          @(negedge clk);
          check("done_after_frame", tx_done, 1);
          check("bits_stable", stable, 1);
          check("no_early_done", early, 0);
          @(negedge clk);
          check("done_one_cycle", tx_done, 0);
          if (exp_q.size() == 0) begin
            check("sb_unexpected_frame", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("frame_bits", frame, exp_frame(e));
            check("frame_data", frame[8:1], e);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  // Receiver model for the default-rate DUT: mid-bit sampling.
  initial begin : mon_b
    logic [7:0] d;
    logic       st, sp, p;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx2 === 1'b0) begin
        repeat (CD2 / 2) @(negedge clk);
        st = tx2;
        for (int i = 0; i < 8; i++) begin
          repeat (CD2) @(negedge clk);
          d[i] = tx2;
        end
        p = 1'b0;
        if (PAR_EN) begin
          repeat (CD2) @(negedge clk);
          p = tx2;
        end
        repeat (CD2) @(negedge clk);
        sp = tx2;
        if (exp2_q.size() == 0) begin
          check("rx_unexpected_frame", exp2_q.size(), 1);
        end else begin
          e = exp2_q.pop_front();
          check("rx_start", st, 0);
          check("rx_byte", d, e);
          check("rx_stop", sp, 1);
          if (PAR_EN) check("rx_parity", p, exp_par(e));
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit push, input bit chk_lat, output bit busy_at_hs);
    int n;
    n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (tx_ready !== 1'b1) check("send_ready_timeout", tx_ready, 1);
    busy_at_hs = tx_busy;
    tx_valid   = 1'b1;
    tx_data_in = d;
    @(posedge clk);
    if (push) exp_q.push_back(d);
    #1;
    tx_valid   = 1'b0;
    tx_data_in = ~d;
    if (chk_lat) begin
      @(negedge clk);
      check("lat_e0_tx_high", tx, 1);
      check("lat_e0_ready_low", tx_ready, 0);
      @(negedge clk);
      check("lat_e1_tx_low", tx, 0);
      check("lat_e1_busy", tx_busy, 1);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", (exp_q.size() == 0 && !mon_busy), 1);
  endtask

  initial begin : stim
    bit hs_busy;
    int n, n_done, n_low;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    send(8'hA5, 1'b1, 1'b1, hs_busy);
    check("a5_idle_at_hs", hs_busy, 0);
    wait_idle();

    // Back-to-back: second byte queued during the first frame.
    send(8'h00, 1'b1, 1'b1, hs_busy);
    send(8'hFF, 1'b1, 1'b0, hs_busy);
    check("b2b_busy_at_hs", hs_busy, 1);
    n = 0;
    while (tx_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("b2b_ready_low_cycles", n, NB * CD + 1);
    check("b2b_start_with_ready", tx, 0);
    wait_idle();
    check("b2b_gap", last_gap, NB * CD + 2);

    send(8'h07, 1'b1, 1'b1, hs_busy);
    wait_idle();

    // Reset during data bit 3 of 0xF0 (line low there).
    send(8'hF0, 1'b0, 1'b1, hs_busy);
    repeat (35) @(negedge clk);
    check("rst_mid_tx_low", tx, 0);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_tx_high", tx, 1);
    check("rst_mid_busy", tx_busy, 0);
    check("rst_mid_done", tx_done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    n_done = 0;
    n_low  = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_done === 1'b1) n_done++;
      if (tx !== 1'b1) n_low++;
    end
    check("rst_mid_no_done", n_done, 0);
    check("rst_mid_line_idle", n_low, 0);
    check("rst_mid_ready", tx_ready, 1);

    // Default-rate loopback.
    @(negedge clk);
    tx_valid2 = 1'b1;
    tx_data2  = 8'h3C;
    @(posedge clk);
    exp2_q.push_back(8'h3C);
    #1 tx_valid2 = 1'b0;
    n = 0;
    while (exp2_q.size() != 0 && n < 12 * CD2) begin
      @(negedge clk);
      n++;
    end
    check("rx_frame_seen", exp2_q.size(), 0);
    repeat (CD2 + 4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serializes one byte per frame onto `tx`: one start bit, 8 data bits LSB first, an optional parity bit, then one stop bit. It is the transmit counterpart of the team's UART receiver and shares its baud parameters, so a looped-back pair interoperates. A one-entry holding register behind a valid/ready handshake lets the host queue the next byte while the current frame is on the line.

## Interface
- `clk_freq`, 50000000: input clock frequency in Hz.
- `baud_rate`, 19200: line rate in bits per second.
- `parity_odd`, 0: 0 selects even parity, 1 selects odd parity. Used only when parity is compiled in.
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst` input 1: asynchronous, active-low reset. It asserts immediately on fall and is released synchronously to `clk` by the integration.
- `tx_valid` input 1: host presents a byte on `tx_data_in`.
- `tx_data_in` input 8: byte to send.
- `tx_ready` output 1: the holding register is empty. A byte is accepted on any edge where `tx_valid && tx_ready`.
- `tx` output 1: serial line. Registered. Idles high.
- `tx_busy` output 1: high while a frame is being shifted (any state other than IDLE).
- `tx_done` output 1: one-cycle pulse at the end of each frame.

## Operation
- Bit period: `clock_divide = clk_freq/baud_rate`, using integer division.
  - `clock_divide` must be at least 2.
  - The bit counter is `$clog2(clock_divide)` bits wide and counts 0 to `clock_divide-1`, then wraps to 0.
- Holding register (`hold_data`, `hold_full`):
  - Accepting a byte sets `hold_full`.
  - Loading the byte into the shifter clears `hold_full`.
  - `tx_ready = !hold_full`.
  - If an accept and a load occur on the same edge, the new byte wins and `hold_full` stays 1.
- State machine:
  - IDLE:
    - `tx=1`, counter held at 0.
    - If `hold_full`: load the shifter from `hold_data`, compute parity, clear `hold_full`, go to START.
  - START: `tx=0` for `clock_divide` cycles, then go to DATA with bit index 0.
  - DATA:
    - `tx` = shifter bit[index] for `clock_divide` cycles.
    - After bit 7, go to PARITY if parity is compiled in, else to STOP.
  - PARITY: `tx` = parity bit for `clock_divide` cycles, then go to STOP.
  - STOP: `tx=1` for `clock_divide` cycles, then go to DONE.
  - DONE: `tx=1`, `tx_done=1` for exactly one cycle, then go to IDLE.
- The shifter is never modified mid-frame. Changes on `tx_data_in` while `tx_ready=0` are ignored.
- Reset values: `tx=1`, `tx_ready=1`, `tx_busy=0`, `tx_done=0`, state IDLE, counter 0, `hold_full=0`.
- Reset mid-frame: `tx` returns high asynchronously. Both the held byte and the in-flight byte are discarded, and no `tx_done` is produced.

## Timing
- Latency from handshake to start bit:
  - Handshake at edge E0, with the machine in IDLE.
  - At edge E1 the state goes to START and `tx` falls. The start bit is visible from E1.
- Every line bit lasts exactly `clock_divide` cycles.
- Frame length:
  - `10*clock_divide` cycles without parity, `11*clock_divide` with parity, measured from `tx` falling to the end of STOP.
  - `tx_done` is high the cycle after STOP completes.
- Back-to-back:
  - `tx_ready` rises the cycle after the load, so the host can queue the next byte during the current frame.
  - Minimum gap between frames: the stop bit plus 2 cycles (DONE and IDLE). The next start bit begins 2 cycles after STOP ends.
- `tx_busy` is high from E1 through the DONE cycle inclusive.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state exists and the frame is 11 bits.
  - Parity bit = `^data` for even parity, or `~^data` when `parity_odd=1`.
- `UART_TX_PARITY_EN` undefined:
  - No PARITY state and no parity logic.
  - The frame is 10 bits (8N1).
  - `parity_odd` is ignored.

## Structure
- Package `uart_pkg` holds:
  - the `tx_state_t` enum: IDLE, START, DATA, PARITY, STOP, DONE;
  - `UART_DATA_BITS = 8`;
  - `UART_START_LEVEL = 1'b0`;
  - `UART_STOP_LEVEL = 1'b1`.
- Sub-module `uart_baud_tick`:
  - Parameter `clock_divide`.
  - Inputs: `clk`, `rst`, `clear`.
  - Output: a `tick` pulse each time the counter wraps.
  - `clear` is held high in IDLE so that each frame is phase-aligned to its start bit.

## Test plan
- Reset: hold `rst=0` with `clk_freq=8`, `baud_rate=1`. Expect `tx=1`, `tx_ready=1`, `tx_busy=0`, `tx_done=0`.
- Single byte 0xA5 (`clock_divide=8`, no parity): expect `tx` to fall 1 cycle after the handshake, then the sequence 0,1,0,1,0,0,1,0,1,1, each level lasting 8 cycles, with `tx_done` pulsing 80 cycles after the fall.
- Back-to-back 0x00 then 0xFF:
  - The second handshake completes while `tx_busy=1`.
  - Expect the second start bit 8+2 cycles after the first stop bit begins.
  - Expect `tx_ready=0` until the second load.
- Parity build with byte 0x07:
  - `parity_odd=0`: parity bit 1 and an 11-bit frame.
  - `parity_odd=1`: parity bit 0.
- Reset mid-frame: assert `rst=0` during DATA bit 3. Expect `tx=1` immediately, no `tx_done`, and after release `tx_ready=1` with the line idle.
- Loopback to the receiver at default parameters (2604 cycles/bit): send 0x3C. The receiver output equals 0x3C after its frame completes.
